desplazador_izquierda_serial: RTL and testbench
===============================================

// Module: desplazador_izquierda_serial
// PURPOSE
//   Bit-serial left shifter, one position per clock, for the teaching ALU datapath.
//   It is the left-shift counterpart of the right-shift arithmetic-extension logic.
//   The right-shift side injects a fill bit at the MSB. This block injects a fill bit
//   at the LSB and checks the bits leaving the MSB for sign loss (arithmetic overflow).
//   It uses the same ControlModo / SelectorOperacion encoding as the ALU shift path.
// PARAMETERS
//   ANCHO       8                 data word width, >= 2
//   ANCHO_CANT  $clog2(ANCHO)     shift-amount width, derived localparam (0..ANCHO-1)
// PORTS
//   Reloj              in   1           single clock, rising edge
//   Reset              in   1           synchronous, active-high
//   Inicio             in   1           start request; sampled only in REPOSO
//   DatoEntrada        in   ANCHO       operand, captured when Inicio is accepted
//   Cantidad           in   ANCHO_CANT  shift count, captured with DatoEntrada
//   ControlModo        in   1           0 = logical left; 1 = mode set by SelectorOperacion
//   SelectorOperacion  in   2           fill/mode select, used only when ControlModo = 1
//   DatoSalida         out  ANCHO       result; held until the next accepted Inicio
//   BitSalida          out  1           last bit shifted out of the MSB (carry)
//   Desborde           out  1           sticky arithmetic-overflow flag for this operation
//   Ocupado            out  1           high from the cycle after acceptance until Listo
//   Listo              out  1           one-cycle completion pulse
// BEHAVIOUR
//   Reset: state = REPOSO; DatoSalida, BitSalida, Desborde, Ocupado and Listo all 0.
//   FSM states: REPOSO -> DESPLAZA -> FIN -> REPOSO.
//   - REPOSO & Inicio:
//       capture DatoEntrada, Cantidad and the mode inputs.
//       clear BitSalida and Desborde.
//       go to DESPLAZA, or to FIN if Cantidad = 0.
//   - DESPLAZA: each cycle does one shift and decrements the counter.
//       Go to FIN on the cycle the counter reaches 0.
//   - FIN: Listo = 1 for exactly one cycle, Ocupado = 0, then go to REPOSO.
//   Latency: Inicio accepted at edge t gives Listo high in cycle t+Cantidad+1.
//     Cantidad = 0 gives Listo at t+1, DatoSalida = DatoEntrada, BitSalida = 0.
//   Per shift: r <= {r[ANCHO-2:0], fill}; BitSalida <= r[ANCHO-1].
//   Fill bit selection:
//     ControlModo=0           : fill = 0 (logical)
//     ControlModo=1, Sel=00   : fill = 0 (arithmetic)
//                               Desborde |= (r[ANCHO-1] ^ r[ANCHO-2]), checked before the shift
//     ControlModo=1, Sel=01   : fill = r[ANCHO-1] (rotate)
//     ControlModo=1, Sel=10   : fill = 1 (ones fill)
//     ControlModo=1, Sel=11   : fill = r[0] (LSB replication, mirror of sign extension)
//   Desborde is updated only in the arithmetic case; in every other mode it stays 0.
//   Mode inputs are latched at acceptance; changes while Ocupado have no effect.
//   Inicio while Ocupado or in FIN is ignored; it is not queued.
//   Inicio in the same cycle Listo is high is also ignored.
//   Reset mid-operation aborts the operation; no Listo is produced.
//   Cantidad is unsigned; all arithmetic is ANCHO_CANT bits wide with no wrap-around.
// STRUCTURE
//   Shared package paquete_desplazador holds:
//     - state enum {REPOSO, DESPLAZA, FIN}
//     - fill-mode constants MODO_ARIT=2'b00, MODO_ROTA=2'b01, MODO_UNOS=2'b10, MODO_LSB=2'b11
//   The fill-bit selection is one combinational sub-module, extension_lsb.
//     Inputs: r[ANCHO-1], r[0], latched ControlModo / SelectorOperacion. Output: fill.
//   FSM, counter and data register stay in this module.
// TESTING (ANCHO = 8)
//   1. ControlModo=0, 8'hB5, Cantidad=3 -> DatoSalida=8'hA8, BitSalida=1, Desborde=0;
//      Listo exactly 4 cycles after acceptance.
//   2. Arithmetic mode (Sel=00), 8'hE0:
//      Cantidad=2 -> 8'h80, Desborde=0; Cantidad=3 -> 8'h00, Desborde=1.
//   3. Rotate 8'h81, Cantidad=1 -> 8'h03, BitSalida=1.
//      Sel=11, 8'h01, Cantidad=4 -> 8'h1F.
//      Sel=10, 8'h00, Cantidad=4 -> 8'h0F.
//   4. Cantidad=0, 8'h5A -> Listo next cycle, DatoSalida=8'h5A, BitSalida=0, Desborde=0.
//   5. Second Inicio (8'hFF) while Ocupado -> ignored; first result unchanged.
//      Inicio on the Listo cycle -> ignored.
//   6. Reset asserted during DESPLAZA -> next edge: all outputs 0, REPOSO, no Listo;
//      a fresh operation then completes normally.

Source files
------------

// File: rtl/desplazador_izquierda_serial_pkg.sv
// paquete_desplazador: FSM states and fill-mode codes for the serial left shifter.
// Revision 1.0
`default_nettype none

package paquete_desplazador;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  localparam logic [1:0] MODO_ARIT = 2'b00;
  localparam logic [1:0] MODO_ROTA = 2'b01;
  localparam logic [1:0] MODO_UNOS = 2'b10;
  localparam logic [1:0] MODO_LSB  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/desplazador_izquierda_serial_if.sv
// desplazador_izquierda_serial_if: request/result bundle of the serial left shifter.
// Revision 1.0
`default_nettype none

interface desplazador_izquierda_serial_if #(
  parameter int ANCHO = 8
);
  localparam int ANCHO_CANT = $clog2(ANCHO);

  logic                  Inicio;
  logic [ANCHO-1:0]      DatoEntrada;
  logic [ANCHO_CANT-1:0] Cantidad;
  logic                  ControlModo;
  logic [1:0]            SelectorOperacion;
  logic [ANCHO-1:0]      DatoSalida;
  logic                  BitSalida;
  logic                  Desborde;
  logic                  Ocupado;
  logic                  Listo;

  modport master (
    output Inicio, DatoEntrada, Cantidad, ControlModo, SelectorOperacion,
    input  DatoSalida, BitSalida, Desborde, Ocupado, Listo
  );

  modport slave (
    input  Inicio, DatoEntrada, Cantidad, ControlModo, SelectorOperacion,
    output DatoSalida, BitSalida, Desborde, Ocupado, Listo
  );

endinterface

`default_nettype wire

// File: rtl/desplazador_izquierda_serial_extension_lsb.sv
// extension_lsb: selects the bit injected at the LSB on each left shift.
// Revision 1.0
`default_nettype none

module extension_lsb
  import paquete_desplazador::*;
(
  input  wire logic       msb,
  input  wire logic       lsb,
  input  wire logic       control_modo,
  input  wire logic [1:0] selector,
  output logic            fill
);

  always_comb begin
    fill = 1'b0;
    if (control_modo) begin
      case (selector)
        MODO_ROTA: fill = msb;
        MODO_UNOS: fill = 1'b1;
        MODO_LSB:  fill = lsb;
        default:   fill = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/desplazador_izquierda_serial.sv
// desplazador_izquierda_serial: bit-serial left shifter with fill select and overflow flag.
// Revision 1.0
`default_nettype none

module desplazador_izquierda_serial
  import paquete_desplazador::*;
#(
  parameter int ANCHO = 8
) (
  input  wire logic                      Reloj,
  input  wire logic                      Reset,
  desplazador_izquierda_serial_if.slave  bus
);

  localparam int ANCHO_CANT = $clog2(ANCHO);

  estado_t               estado;
  estado_t               estado_sig;
  logic [ANCHO-1:0]      dato;
  logic [ANCHO_CANT-1:0] cuenta;
  logic                  modo_ctrl;
  logic [1:0]            modo_sel;
  logic                  bit_salida;
  logic                  desborde;
  logic                  fill;
  logic                  es_aritmetico;

  extension_lsb u_extension_lsb (
    .msb          (dato[ANCHO-1]),
    .lsb          (dato[0]),
    .control_modo (modo_ctrl),
    .selector     (modo_sel),
    .fill         (fill)
  );

  assign es_aritmetico = modo_ctrl && (modo_sel == MODO_ARIT);

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      estado     <= REPOSO;
      dato       <= '0;
      cuenta     <= '0;
      modo_ctrl  <= 1'b0;
      modo_sel   <= 2'b00;
      bit_salida <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      estado <= estado_sig;
      case (estado)
        REPOSO: begin
          if (bus.Inicio) begin
            dato       <= bus.DatoEntrada;
            cuenta     <= bus.Cantidad;
            modo_ctrl  <= bus.ControlModo;
            modo_sel   <= bus.SelectorOperacion;
            bit_salida <= 1'b0;
            desborde   <= 1'b0;
          end
        end
        DESPLAZA: begin
          dato       <= {dato[ANCHO-2:0], fill};
          bit_salida <= dato[ANCHO-1];
          cuenta     <= cuenta - ANCHO_CANT'(1);
          // Sign loss is judged on the two top bits before they move.
          if (es_aritmetico) begin
            desborde <= desborde | (dato[ANCHO-1] ^ dato[ANCHO-2]);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    estado_sig  = estado;
    bus.Ocupado = 1'b0;
    bus.Listo   = 1'b0;
    case (estado)
      REPOSO: begin
        if (bus.Inicio) begin
          estado_sig = (bus.Cantidad == '0) ? FIN : DESPLAZA;
        end
      end
      DESPLAZA: begin
        bus.Ocupado = 1'b1;
        if (cuenta == ANCHO_CANT'(1)) begin
          estado_sig = FIN;
        end
      end
      FIN: begin
        bus.Listo  = 1'b1;
        estado_sig = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  assign bus.DatoSalida = dato;
  assign bus.BitSalida  = bit_salida;
  assign bus.Desborde   = desborde;

endmodule

`default_nettype wire

// File: tb/tb_desplazador_izquierda_serial.sv
// tb_desplazador_izquierda_serial: directed table, random vs. reference model, corner sequences.
// Revision 1.0
`default_nettype none

module tb_desplazador_izquierda_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pasados = 0;
  int   total   = 0;

  always #5 clk = ~clk;

  desplazador_izquierda_serial_if #(.ANCHO(8)) bus ();

  desplazador_izquierda_serial #(.ANCHO(8)) dut (
    .Reloj (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    int         n;
    logic       c;
    logic [1:0] s;
    logic [7:0] eo;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tabla [7];

  task automatic chk(input string nombre, input logic [31:0] real_v, input logic [31:0] esperado);
    total++;
    if (real_v === esperado) pasados++;
    else $display("FAIL %s: got %0h expected %0h", nombre, real_v, esperado);
  endtask

  // Closed-form result of n left shifts from the mode rules.
  function automatic void modelo(input logic [7:0] d, input int n, input logic c, input logic [1:0] s,
                                 output logic [7:0] r, output logic b, output logic o);
    int v, msk, sh, top;
    v   = int'(d);
    msk = (1 << n) - 1;
    sh  = (v << n) & 255;
    b   = (n == 0) ? 1'b0 : 1'((v >> (8 - n)) & 1);
    o   = 1'b0;
    if (!c || s == 2'b00) r = 8'(sh);
    else if (s == 2'b01)  r = 8'(sh | (v >> (8 - n)));
    else if (s == 2'b10)  r = 8'(sh | msk);
    else                  r = 8'(sh | (d[0] ? msk : 0));
    if (c && s == 2'b00 && n > 0) begin
      top = v >> (7 - n);
      o   = !(top == 0 || top == ((1 << (n + 1)) - 1));
    end
  endfunction

  task automatic run_op(input logic [7:0] d, input int n, input logic c, input logic [1:0] s,
                        output logic [7:0] r, output logic b, output logic o, output int lat,
                        output logic ocup0, output logic ocupl);
    @(negedge clk);
    bus.Inicio            = 1'b1;
    bus.DatoEntrada       = d;
    bus.Cantidad          = 3'(n);
    bus.ControlModo       = c;
    bus.SelectorOperacion = s;
    @(posedge clk);
    #1;
    bus.Inicio            = 1'b0;
    bus.DatoEntrada       = 8'($urandom);
    bus.Cantidad          = 3'($urandom);
    bus.ControlModo       = 1'($urandom);
    bus.SelectorOperacion = 2'($urandom);
    ocup0 = bus.Ocupado;
    lat   = 0;
    while (!bus.Listo && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r     = bus.DatoSalida;
    b     = bus.BitSalida;
    o     = bus.Desborde;
    ocupl = bus.Ocupado;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] r, er;
  logic       b, o, eb, eo, oc0, ocl;
  int         lat, listos;

  initial begin
    bus.Inicio            = 1'b0;
    bus.DatoEntrada       = '0;
    bus.Cantidad          = '0;
    bus.ControlModo       = 1'b0;
    bus.SelectorOperacion = 2'b00;

    tabla[0] = '{8'hB5, 3, 1'b0, 2'b00, 8'hA8, 1'b1, 1'b0};
    tabla[1] = '{8'hE0, 2, 1'b1, 2'b00, 8'h80, 1'b1, 1'b0};
    tabla[2] = '{8'hE0, 3, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1};
    tabla[3] = '{8'h81, 1, 1'b1, 2'b01, 8'h03, 1'b1, 1'b0};
    tabla[4] = '{8'h01, 4, 1'b1, 2'b11, 8'h1F, 1'b0, 1'b0};
    tabla[5] = '{8'h00, 4, 1'b1, 2'b10, 8'h0F, 1'b0, 1'b0};
    tabla[6] = '{8'h5A, 0, 1'b0, 2'b00, 8'h5A, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset DatoSalida", 32'(bus.DatoSalida), 0);
    chk("reset BitSalida",  32'(bus.BitSalida), 0);
    chk("reset Desborde",   32'(bus.Desborde), 0);
    chk("reset Ocupado",    32'(bus.Ocupado), 0);
    chk("reset Listo",      32'(bus.Listo), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tabla[i]) begin
      run_op(tabla[i].d, tabla[i].n, tabla[i].c, tabla[i].s, r, b, o, lat, oc0, ocl);
      chk($sformatf("tabla%0d DatoSalida", i), 32'(r), 32'(tabla[i].eo));
      chk($sformatf("tabla%0d BitSalida", i), 32'(b), 32'(tabla[i].eb));
      chk($sformatf("tabla%0d Desborde", i), 32'(o), 32'(tabla[i].ed));
      chk($sformatf("tabla%0d latencia", i), 32'(lat), 32'(tabla[i].n));
    end

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      int         n;
      logic       c;
      logic [1:0] s;
      d = 8'($urandom);
      n = int'($urandom_range(0, 7));
      c = 1'($urandom);
      s = 2'($urandom);
      if (k % 4 == 0) begin
        c = 1'b1;
        s = 2'b00;
      end
      modelo(d, n, c, s, er, eb, eo);
      run_op(d, n, c, s, r, b, o, lat, oc0, ocl);
      chk($sformatf("rnd%0d DatoSalida", k), 32'(r), 32'(er));
      chk($sformatf("rnd%0d BitSalida", k), 32'(b), 32'(eb));
      chk($sformatf("rnd%0d Desborde", k), 32'(o), 32'(eo));
      chk($sformatf("rnd%0d latencia", k), 32'(lat), 32'(n));
      chk($sformatf("rnd%0d Ocupado inicio", k), 32'(oc0), 32'(n > 0));
      chk($sformatf("rnd%0d Ocupado en Listo", k), 32'(ocl), 0);
    end

    // Inicio while busy, then Inicio on the Listo cycle: both must be dropped.
    @(negedge clk);
    bus.Inicio = 1'b1; bus.DatoEntrada = 8'hB5; bus.Cantidad = 3'd3;
    bus.ControlModo = 1'b0; bus.SelectorOperacion = 2'b00;
    @(posedge clk); #1;
    bus.Inicio = 1'b1; bus.DatoEntrada = 8'hFF; bus.Cantidad = 3'd0;
    bus.ControlModo = 1'b1; bus.SelectorOperacion = 2'b10;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    lat = 1;
    while (!bus.Listo && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("ocupado latencia", 32'(lat), 3);
    chk("ocupado DatoSalida", 32'(bus.DatoSalida), 32'h A8);
    @(negedge clk);
    bus.Inicio = 1'b1; bus.DatoEntrada = 8'h5A; bus.Cantidad = 3'd0;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    chk("inicio en Listo: Listo", 32'(bus.Listo), 0);
    @(posedge clk); #1;
    chk("inicio en Listo: Listo tarde", 32'(bus.Listo), 0);
    chk("inicio en Listo: DatoSalida", 32'(bus.DatoSalida), 32'h A8);

    // Reset in the middle of DESPLAZA aborts without a Listo.
    @(negedge clk);
    bus.Inicio = 1'b1; bus.DatoEntrada = 8'hC0; bus.Cantidad = 3'd5;
    bus.ControlModo = 1'b1; bus.SelectorOperacion = 2'b00;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset Desborde", 32'(bus.Desborde), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset medio DatoSalida", 32'(bus.DatoSalida), 0);
    chk("reset medio BitSalida", 32'(bus.BitSalida), 0);
    chk("reset medio Desborde", 32'(bus.Desborde), 0);
    chk("reset medio Ocupado", 32'(bus.Ocupado), 0);
    chk("reset medio Listo", 32'(bus.Listo), 0);
    @(negedge clk);
    rst = 1'b0;
    listos = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.Listo) listos++;
    end
    chk("reset medio sin Listo", 32'(listos), 0);
    run_op(8'h81, 1, 1'b1, 2'b01, r, b, o, lat, oc0, ocl);
    chk("post-reset DatoSalida", 32'(r), 32'h03);
    chk("post-reset BitSalida", 32'(b), 1);
    chk("post-reset latencia", 32'(lat), 1);

    $display("%0d/%0d checks passed", pasados, total);
    $finish;
  end

endmodule

`default_nettype wire
